// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, sweep FSM encoding and MISR polynomial.
//   Used by alu_sweep_ctrl and alu_sig_misr (the latter only built
//   when ALU_SWEEP_SIG_EN is defined).
package alu_pkg;
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_SLL  = 3'd7;
    localparam logic [2:0] LAST_OP = OP_SLL;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_HOLD
    } sweep_state_t;
endpackage

// File: rtl/alu_sig_misr.sv
// alu_sig_misr: multiple-input signature register over the result stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (new operand pair accepted)
//   en         : fold d into the signature this cycle
//   d          : data word to fold
//   sig        : current signature
module alu_sig_misr
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);
    localparam logic [W-1:0] POLY = W'(MISR_POLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ d;
    end
endmodule

// File: rtl/alu_sweep_ctrl.sv
// alu_sweep_ctrl: sequences one operand pair through ALU ops 0..7 and
//   streams one sampled result record per op.
//   Optional: define ALU_SWEEP_SIG_EN to add a result-signature output sig.
//   clk, rst_n          : clock, asynchronous active-low reset
//   abort               : synchronous sweep cancel (beats all handshakes)
//   in_valid/in_ready   : operand pair handshake, in_a/in_b operands
//   A, B, ALU_OP        : drive the combinational ALU
//   F, ZF, OF           : ALU result and flags
//   res_valid/res_ready : result record handshake
//   res_op, res_f, res_zf, res_of, res_last : result record
//   busy                : sweep in progress
//   sig                 : (ALU_SWEEP_SIG_EN only) MISR over records
module alu_sweep_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       ALU_OP,
    input  logic [WIDTH-1:0] F,
    input  logic             ZF,
    input  logic             OF,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_op,
    output logic [WIDTH-1:0] res_f,
    output logic             res_zf,
    output logic             res_of,
    output logic             res_last,
`ifdef ALU_SWEEP_SIG_EN
    output logic [WIDTH-1:0] sig,
`endif
    output logic             busy
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    sweep_state_t   state;
    logic [CW-1:0]  cnt;

    assign in_ready = (state == ST_IDLE);
    assign busy     = !in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            A         <= '0;
            B         <= '0;
            ALU_OP    <= '0;
            res_valid <= 1'b0;
            res_op    <= '0;
            res_f     <= '0;
            res_zf    <= 1'b0;
            res_of    <= 1'b0;
            res_last  <= 1'b0;
        end else if (abort) begin
            // Operands and opcode stay put; only the record stream is cancelled.
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    A      <= in_a;
                    B      <= in_b;
                    ALU_OP <= OP_AND;
                    cnt    <= '0;
                    state  <= ST_APPLY;
                end
                ST_APPLY: if (cnt == CNT_LAST) begin
                    res_f     <= F;
                    res_zf    <= ZF;
                    res_of    <= OF;
                    res_op    <= ALU_OP;
                    res_last  <= (ALU_OP == LAST_OP);
                    res_valid <= 1'b1;
                    state     <= ST_HOLD;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (ALU_OP == LAST_OP) begin
                        state <= ST_IDLE;
                    end else begin
                        ALU_OP <= ALU_OP + 3'd1;
                        cnt    <= '0;
                        state  <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SWEEP_SIG_EN
    // Flags are folded into the two low bits of the result word.
    alu_sig_misr #(.W(WIDTH)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_valid && in_ready && !abort),
        .en    (res_valid && res_ready && !abort),
        .d     (res_f ^ WIDTH'({res_zf, res_of})),
        .sig   (sig)
    );
`endif
endmodule

// File: doc/alu_sweep_ctrl.md
# alu_sweep_ctrl

Hardware sequencer that drives the combinational ALU: accepts one operand pair over a valid/ready handshake, applies it with every ALU_OP code 0..7 in order, samples F/ZF/OF after a settle interval, and streams one result record per op to a downstream consumer. It sits between the operand source (switches/ROM/host) and the display or checker logic on the board, replacing the simulation stimulus sweep with synthesizable control.

## Interface
- WIDTH, 32, operand/result width
- SETTLE, 1, cycles ALU_OP/A/B are held before sampling (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous sweep cancel
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a, in_b  in  WIDTH  operand pair
- A, B  out  WIDTH  ALU operands (to ALU)
- ALU_OP  out  3  ALU opcode (to ALU)
- F  in  WIDTH  ALU result
- ZF, OF  in  1  ALU zero/overflow flags
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_op  out  3  opcode of record
- res_f  out  WIDTH  sampled F
- res_zf, res_of  out  1  sampled flags
- res_last  out  1  record is op 7
- busy  out  1  sweep in progress

## Operation
- States: IDLE, APPLY, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready: latch in_a/in_b into A/B, ALU_OP←0, settle counter←0, go APPLY.
- APPLY: A/B/ALU_OP stable. Counter increments each cycle; in the cycle counter==SETTLE-1, capture F/ZF/OF/ALU_OP into res_* at the clock edge, set res_valid, res_last=(ALU_OP==7), go HOLD.
- HOLD: res_* stable while res_valid&!res_ready. On res_valid&res_ready: res_valid←0; if ALU_OP==7 go IDLE, else ALU_OP←ALU_OP+1, counter←0, go APPLY.
- in_valid outside IDLE ignored (in_ready=0).
- abort (any state, highest priority over handshakes): next state IDLE, res_valid←0, res_last←0; A/B/ALU_OP hold last values. The one sanctioned drop of res_valid without a handshake.
- busy = (state != IDLE).
- ALU_OP wraps never: sweep ends at 7; counter width clog2(SETTLE+1).

## Timing
- Reset: state IDLE; A, B, ALU_OP, res_f, res_op = 0; res_valid, res_zf, res_of, res_last, busy = 0; in_ready = 1.
- Reset asserted mid-sweep: immediate return to reset values; partial sweep discarded.
- Cycle 0 accept → cycle 1 ALU_OP=0 on port → res_valid high in cycle SETTLE+1.
- With res_ready tied high: one record every SETTLE+1 cycles; 8(SETTLE+1) cycles accept-to-IDLE; in_ready high again the cycle after op-7 handshake. SETTLE=1: 16 cycles.
- Backpressure: each stalled cycle in HOLD adds one cycle; no record lost or duplicated.

## Configuration
- ALU_SWEEP_SIG_EN defined: adds output sig (WIDTH) — 32-bit MISR (poly 0x04C11DB7) folding res_f^{res_zf,res_of} on every res handshake; cleared to 0 on pair accept and reset; valid once res_last handshakes.
- Undefined: no sig port, no MISR logic; behaviour otherwise identical.

## Structure
- alu_pkg: ALU_OP localparams (AND=0, OR=1, XOR=2, NOR=3, ADD=4, SUB=5, SLT=6, SLL=7), sweep state encoding, LAST_OP=7, MISR polynomial.
- Sub-module alu_sig_misr (instantiated only under ALU_SWEEP_SIG_EN).
- Bench pairs alu_sweep_ctrl with the existing ALU.

## Test plan
- Reset then A=1e45d9f9, B=d4c41db0, res_ready=1, SETTLE=1 → 8 records, op 0..7, first at cycle 2; op0 res_f=144419b0; op4 res_f=f309f7a9, res_of=0; res_last only on op7; in_ready back at cycle 17.
- A=73254ed5, B=73254ed5 → op2 (XOR) res_f=0, res_zf=1; op5 (SUB) res_zf=1.
- res_ready toggled 1-of-3 cycles → records identical in content/order to free-running run, each held stable until accepted.
- abort asserted while in HOLD on op3 → next cycle IDLE, res_valid=0, in_ready=1; following new pair restarts at op0.
- rst_n pulsed low mid-APPLY of op5 → all outputs at reset values asynchronously; new sweep runs normally.
- ALU_SWEEP_SIG_EN build: two identical sweeps give identical sig; flipping one bit of B gives different sig.
